// File: rtl/servo_output_limiter.sv
// Output conditioning between the IIR servo filter and the DAC: rail clamp, per-tick
// slew limit and railing flags. Define LIMITER_STICKY_RAIL_EN to latch the rail flags.
module servo_output_limiter #(
  parameter int SIGNAL_SIZE = 16,
  parameter int TICK_DIV    = 26,
  parameter int RAIL_HOLD   = 8
) (
  input  logic                          clk_in,
  input  logic                          rst_in,
  input  logic                          on_in,
  input  logic signed [SIGNAL_SIZE-1:0] signal_in,
  input  logic signed [SIGNAL_SIZE-1:0] max_in,
  input  logic signed [SIGNAL_SIZE-1:0] min_in,
  input  logic        [SIGNAL_SIZE-1:0] slew_in,
  input  logic                          clear_rail_in,
  output logic signed [SIGNAL_SIZE-1:0] signal_out,
  output logic                          rail_hi_out,
  output logic                          rail_lo_out,
  output logic                          bound_err_out
);

  localparam int               CNT_W     = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CNT_W-1:0] TICK_LAST = CNT_W'(TICK_DIV - 1);
  localparam logic [7:0]       HOLD      = 8'(RAIL_HOLD);

  typedef enum logic {
    ST_BYPASS,
    ST_ACTIVE
  } state_e;

  state_e                          state_q, state_d;
  logic [CNT_W-1:0]                tick_cnt_q, tick_cnt_d, tick_cnt_cur;
  logic signed [SIGNAL_SIZE-1:0]   out_q, out_d;
  logic [7:0]                      hi_cnt_q, hi_cnt_d, lo_cnt_q, lo_cnt_d;
  logic                            rail_hi_q, rail_hi_d, rail_lo_q, rail_lo_d;
  logic                            bound_err_q, bound_err_d;

  logic                            tick, bounds_bad, at_hi, at_lo;
  logic signed [SIGNAL_SIZE-1:0]   target, out_slewed;
  logic signed [SIGNAL_SIZE:0]     diff, slew_ext, step;

  function automatic logic [7:0] sat_inc(input logic [7:0] cnt);
    return (cnt == HOLD) ? cnt : cnt + 8'd1;
  endfunction

  // Clamp and slew arithmetic, one bit wider than the signal so the difference never wraps.
  always_comb begin : datapath
    bounds_bad = (min_in > max_in);
    if (signal_in > max_in)      target = max_in;
    else if (signal_in < min_in) target = min_in;
    else                         target = signal_in;

    diff     = {target[SIGNAL_SIZE-1], target} - {out_q[SIGNAL_SIZE-1], out_q};
    slew_ext = {1'b0, slew_in};
    if (diff > slew_ext)       step = slew_ext;
    else if (diff < -slew_ext) step = -slew_ext;
    else                       step = diff;
    // The step never crosses the target, so the narrow sum is exact.
    out_slewed = out_q + step[SIGNAL_SIZE-1:0];

    at_hi = (signal_in >= max_in) || (min_in == max_in);
    at_lo = (signal_in <= min_in) || (min_in == max_in);
  end

  always_comb begin : control
    // NOTE: every variable gets a default first so no path leaves one unassigned (no latches).
    state_d     = on_in ? ST_ACTIVE : ST_BYPASS;
    tick_cnt_d  = tick_cnt_q;
    out_d       = out_q;
    hi_cnt_d    = hi_cnt_q;
    lo_cnt_d    = lo_cnt_q;
    rail_hi_d   = rail_hi_q;
    rail_lo_d   = rail_lo_q;
    bound_err_d = bound_err_q;

    // Entering ACTIVE always starts the tick count from zero.
    tick_cnt_cur = (state_q == ST_ACTIVE) ? tick_cnt_q : '0;
    tick         = on_in && (tick_cnt_cur == TICK_LAST);

    if (!on_in) begin
      out_d       = signal_in;
      tick_cnt_d  = '0;
      hi_cnt_d    = '0;
      lo_cnt_d    = '0;
      rail_hi_d   = 1'b0;
      rail_lo_d   = 1'b0;
      bound_err_d = 1'b0;
    end else begin
      tick_cnt_d = tick ? '0 : tick_cnt_cur + 1'b1;

      if (tick) begin
        if (bounds_bad) begin
          bound_err_d = 1'b1;
        end else begin
          bound_err_d = 1'b0;
          out_d       = (slew_in == '0) ? target : out_slewed;
          hi_cnt_d    = at_hi ? sat_inc(hi_cnt_q) : 8'd0;
          lo_cnt_d    = at_lo ? sat_inc(lo_cnt_q) : 8'd0;
        end
      end

      if (clear_rail_in) begin
        hi_cnt_d = '0;
        lo_cnt_d = '0;
      end

`ifdef LIMITER_STICKY_RAIL_EN
      rail_hi_d = !clear_rail_in && (rail_hi_q || (hi_cnt_d == HOLD));
      rail_lo_d = !clear_rail_in && (rail_lo_q || (lo_cnt_d == HOLD));
`else
      rail_hi_d = (hi_cnt_d == HOLD);
      rail_lo_d = (lo_cnt_d == HOLD);
`endif
    end
  end

  always_ff @(posedge clk_in) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (rst_in) begin
      state_q     <= ST_BYPASS;
      tick_cnt_q  <= '0;
      out_q       <= '0;
      hi_cnt_q    <= '0;
      lo_cnt_q    <= '0;
      rail_hi_q   <= 1'b0;
      rail_lo_q   <= 1'b0;
      bound_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      tick_cnt_q  <= tick_cnt_d;
      out_q       <= out_d;
      hi_cnt_q    <= hi_cnt_d;
      lo_cnt_q    <= lo_cnt_d;
      rail_hi_q   <= rail_hi_d;
      rail_lo_q   <= rail_lo_d;
      bound_err_q <= bound_err_d;
    end
  end

  assign signal_out    = out_q;
  assign rail_hi_out   = rail_hi_q;
  assign rail_lo_out   = rail_lo_q;
  assign bound_err_out = bound_err_q;

endmodule

// File: tb/tb_servo_output_limiter.sv
// Self-checking bench for servo_output_limiter: directed scenarios plus randomized
// traffic, each cycle compared against an integer-arithmetic reference model.
module tb_servo_output_limiter;

  localparam int W  = 16;
  localparam int TD = 26;
  localparam int RH = 8;
`ifdef LIMITER_STICKY_RAIL_EN
  localparam bit STICKY = 1'b1;
`else
  localparam bit STICKY = 1'b0;
`endif

  logic                clk_in = 1'b0;
  logic                rst_in = 1'b1;
  logic                on_in = 1'b0;
  logic signed [W-1:0] signal_in = '0;
  logic signed [W-1:0] max_in = '0;
  logic signed [W-1:0] min_in = '0;
  logic        [W-1:0] slew_in = '0;
  logic                clear_rail_in = 1'b0;
  logic signed [W-1:0] signal_out;
  logic                rail_hi_out, rail_lo_out, bound_err_out;

  int checks = 0;
  int errors = 0;

  // Reference model state, plain integers.
  int m_out, m_hi, m_lo, m_cnt;
  bit m_berr, m_rhi, m_rlo, m_active;

  servo_output_limiter #(
    .SIGNAL_SIZE(W),
    .TICK_DIV   (TD),
    .RAIL_HOLD  (RH)
  ) dut (
    .clk_in       (clk_in),
    .rst_in       (rst_in),
    .on_in        (on_in),
    .signal_in    (signal_in),
    .max_in       (max_in),
    .min_in       (min_in),
    .slew_in      (slew_in),
    .clear_rail_in(clear_rail_in),
    .signal_out   (signal_out),
    .rail_hi_out  (rail_hi_out),
    .rail_lo_out  (rail_lo_out),
    .bound_err_out(bound_err_out)
  );

  always #5 clk_in = ~clk_in;

  task automatic check(input string tag, input logic signed [31:0] obs,
                       input logic signed [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
    end
  endtask

  task automatic model_update();
    int sig, mx, mn, slew, cur, target, d;
    bit tick;
    sig  = int'(signal_in);
    mx   = int'(max_in);
    mn   = int'(min_in);
    slew = int'(slew_in);
    if (rst_in) begin
      m_out = 0; m_hi = 0; m_lo = 0; m_cnt = 0;
      m_berr = 0; m_rhi = 0; m_rlo = 0; m_active = 0;
      return;
    end
    if (!on_in) begin
      m_out = sig; m_hi = 0; m_lo = 0; m_cnt = 0;
      m_berr = 0; m_rhi = 0; m_rlo = 0; m_active = 0;
      return;
    end
    cur      = m_active ? m_cnt : 0;
    m_active = 1;
    tick     = (cur == TD - 1);
    m_cnt    = tick ? 0 : cur + 1;
    if (tick) begin
      if (mn > mx) begin
        m_berr = 1;
      end else begin
        m_berr = 0;
        target = (sig > mx) ? mx : (sig < mn) ? mn : sig;
        if (slew == 0) begin
          m_out = target;
        end else begin
          d = target - m_out;
          if (d > slew)  d = slew;
          if (d < -slew) d = -slew;
          m_out = m_out + d;
        end
        m_hi = (sig >= mx || mn == mx) ? ((m_hi < RH) ? m_hi + 1 : RH) : 0;
        m_lo = (sig <= mn || mn == mx) ? ((m_lo < RH) ? m_lo + 1 : RH) : 0;
      end
    end
    if (clear_rail_in) begin
      m_hi = 0; m_lo = 0; m_rhi = 0; m_rlo = 0;
    end else if (STICKY) begin
      m_rhi = m_rhi || (m_hi == RH);
      m_rlo = m_rlo || (m_lo == RH);
    end else begin
      m_rhi = (m_hi == RH);
      m_rlo = (m_lo == RH);
    end
  endtask

  task automatic cycle();
    @(posedge clk_in);
    model_update();
    #1;
    check("model_out", signal_out, m_out);
    check("model_rail_hi", rail_hi_out, m_rhi);
    check("model_rail_lo", rail_lo_out, m_rlo);
    check("model_bound_err", bound_err_out, m_berr);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  int saved_out;

  initial begin
    // Reset held two clocks while bypass would otherwise pass 777 through.
    signal_in = 16'sd777;
    run(2);
    check("reset_out", signal_out, 0);
    check("reset_flags", {rail_hi_out, rail_lo_out, bound_err_out}, 0);
    rst_in = 1'b0;

    // Bypass.
    signal_in = 16'sd1234;
    cycle();
    check("bypass_out", signal_out, 1234);

    // Clamp on the first tick after entry; output holds until then.
    on_in = 1'b1; max_in = 16'sd1000; min_in = -16'sd1000; slew_in = '0;
    signal_in = 16'sd5000;
    run(TD - 1);
    check("clamp_hold", signal_out, 1234);
    cycle();
    check("clamp_out", signal_out, 1000);

    // Slew ramp from zero.
    on_in = 1'b0; signal_in = '0;
    cycle();
    on_in = 1'b1; max_in = 16'sd32767; min_in = -16'sd32767; slew_in = 16'd100;
    signal_in = 16'sd350;
    run(TD);
    check("slew_1", signal_out, 100);
    run(TD - 1);
    check("slew_hold", signal_out, 100);
    cycle();
    check("slew_2", signal_out, 200);
    run(TD);
    check("slew_3", signal_out, 300);
    run(TD);
    check("slew_4", signal_out, 350);

    // Lower rail flag after RAIL_HOLD railed ticks.
    on_in = 1'b0; signal_in = -16'sd2000;
    cycle();
    on_in = 1'b1; max_in = 16'sd1000; min_in = -16'sd1000; slew_in = '0;
    run((RH - 1) * TD);
    check("rail_lo_early", rail_lo_out, 0);
    run(TD);
    check("rail_lo_set", rail_lo_out, 1);
    check("rail_hi_quiet", rail_hi_out, 0);
    check("rail_clamped_out", signal_out, -1000);

    // Clear coinciding with a tick wins over the increment.
    run(TD - 1);
    clear_rail_in = 1'b1;
    cycle();
    clear_rail_in = 1'b0;
    check("rail_clear_on_tick", rail_lo_out, 0);

    // Flag after release: sticky build keeps it until cleared.
    run(RH * TD);
    check("rail_lo_reset", rail_lo_out, 1);
    signal_in = '0;
    run(TD);
    check("rail_lo_release", rail_lo_out, STICKY ? 1 : 0);
    clear_rail_in = 1'b1;
    cycle();
    clear_rail_in = 1'b0;
    check("rail_lo_cleared", rail_lo_out, 0);

    // Inverted bounds.
    on_in = 1'b0; signal_in = 16'sd123;
    cycle();
    saved_out = int'(signal_out);
    on_in = 1'b1; min_in = 16'sd500; max_in = -16'sd500; signal_in = '0;
    run(TD);
    check("bad_bound_err", bound_err_out, 1);
    check("bad_bound_hold", signal_out, saved_out);
    min_in = -16'sd500; max_in = 16'sd500;
    run(TD - 1);
    check("bad_bound_sticks", bound_err_out, 1);
    cycle();
    check("bad_bound_clear", bound_err_out, 0);
    check("bad_bound_out", signal_out, 0);

    // Reset mid-ramp returns the output to zero at once.
    slew_in = 16'd10; signal_in = 16'sd400;
    run(TD + 3);
    rst_in = 1'b1;
    cycle();
    rst_in = 1'b0;
    check("mid_ramp_reset", signal_out, 0);

    // Randomized traffic in blocks of fixed rails/slew and signal bias.
    for (int blk = 0; blk < 12; blk++) begin
      int rmode, smode;
      rmode = int'($urandom_range(0, 9));
      if (rmode == 0) begin
        min_in = 16'(int'($urandom_range(0, 1500)));
        max_in = 16'(-int'($urandom_range(1, 1500)));
      end else if (rmode == 1) begin
        min_in = 16'(int'($urandom_range(0, 2000)) - 1000);
        max_in = min_in;
      end else if (rmode == 2) begin
        min_in = -16'sd32768;
        max_in = 16'sd32767;
      end else begin
        min_in = 16'(-int'($urandom_range(0, 1500)));
        max_in = 16'(int'($urandom_range(0, 1500)));
      end
      case ($urandom_range(0, 3))
        0:       slew_in = '0;
        1:       slew_in = 16'hFFFF;
        default: slew_in = 16'($urandom_range(1, 400));
      endcase
      smode = int'($urandom_range(0, 2));
      for (int i = 0; i < 350; i++) begin
        if (smode == 1)      signal_in = 16'sd3000;
        else if (smode == 2) signal_in = -16'sd3000;
        else if ($urandom_range(0, 9) == 0) signal_in = 16'($urandom);
        else signal_in = 16'(int'($urandom_range(0, 5000)) - 2500);
        on_in         = ($urandom_range(0, 999) != 0);
        rst_in        = ($urandom_range(0, 1999) == 0);
        clear_rail_in = ($urandom_range(0, 249) == 0);
        cycle();
      end
    end
    rst_in = 1'b0; clear_rail_in = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
